// File: rtl/seq_divider_pkg.sv
// Shared lab-wide definitions for the sequential divider slice.
// Latency: none (constants only).
// Backpressure: none (constants only).
//
// Contents: default operand widths and the controller state encoding.
package seq_divider_pkg;

  localparam int N_DEFAULT = 8;  // dividend / quotient width
  localparam int D_DEFAULT = 4;  // divisor / remainder width

  // Controller state encoding; the unused code 2'd3 falls back to IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted remainder.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to use it.
//
// Ports:
//   shifted  (D+1) partial remainder after shifting in the next dividend bit
//   divisor  D     divisor, never zero while the caller is running
//   rem_next D     remainder after the conditional subtract
//   q_bit    1     quotient bit produced by this step
module seq_divider_div_step #(
  parameter int D = seq_divider_pkg::D_DEFAULT
) (
  input  logic [D:0]   shifted,
  input  logic [D-1:0] divisor,
  output logic [D-1:0] rem_next,
  output logic         q_bit
);

  logic [D:0] diff;

  // The incoming remainder is always below the divisor, so shifted < 2*divisor
  // and shifted - divisor lies in (-2^D, 2^D). Within D+1 bits the MSB of the
  // difference is therefore exactly the borrow: clear means shifted >= divisor.
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[D];
  assign rem_next = q_bit ? diff[D-1:0] : shifted[D-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Latency: results and Done after N edges following the accepting edge; divide-by-zero finishes on the accepting edge.
// Backpressure: Start is honoured only in IDLE; requests in RUN or DONE are dropped, never queued.
//
// Ports:
//   Clock, Reset_b        clock and synchronous active-low reset
//   Start                 request pulse with Dividend (N) and Divisor (D)
//   Quotient, Remainder   registered results of the last completed operation
//   Busy, Done, DivByZero in-progress level, completion pulse, zero-divisor flag
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int D = D_DEFAULT
) (
  input  logic         Clock,
  input  logic         Reset_b,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [D-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [D-1:0] Remainder,
  output logic         Busy,
  output logic         Done,
  output logic         DivByZero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  logic [1:0]    state;
  logic [N-1:0]  q_reg;     // dividend shifts out the top, quotient bits in the bottom
  logic [D-1:0]  r_reg;     // partial remainder; always below div_reg
  logic [D-1:0]  div_reg;
  logic [CW-1:0] count;

  logic [D:0]    shifted;
  logic [D-1:0]  rem_next;
  logic          q_bit;
  logic [N-1:0]  q_next;

  assign shifted = {r_reg, q_reg[N-1]};
  assign q_next  = {q_reg[N-2:0], q_bit};

  seq_divider_div_step #(.D(D)) u_step (
    .shifted  (shifted),
    .divisor  (div_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state     <= S_IDLE;
      q_reg     <= '0;
      r_reg     <= '0;
      div_reg   <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (Divisor != '0) begin
              div_reg <= Divisor;
              q_reg   <= Dividend;
              r_reg   <= '0;
              count   <= '0;
              Busy    <= 1'b1;
              state   <= S_RUN;
            end else begin
              // Zero divisor: report saturated quotient immediately, skip RUN.
              Quotient  <= '1;
              Remainder <= Dividend[D-1:0];
              DivByZero <= 1'b1;
              Done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_RUN: begin
          q_reg <= q_next;
          r_reg <= rem_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            Quotient  <= q_next;
            Remainder <= rem_next;
            DivByZero <= 1'b0;
            Done      <= 1'b1;
            Busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, handshake corner cases, random ops vs a/b model.
module tb_seq_divider;

  logic       Clock;
  logic       Reset_b;
  logic       Start;
  logic [7:0] Dividend;
  logic [3:0] Divisor;
  logic [7:0] Quotient;
  logic [3:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivByZero;

  int total;
  int bad;

  seq_divider dut (
    .Clock     (Clock),
    .Reset_b   (Reset_b),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_dbz;
    int         exp_lat;   // edges after the accepting edge until Done is seen
    int         exp_busy;  // post-edge samples with Busy high
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Issue one operation from IDLE, wait (bounded) for Done, then return to IDLE.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       output logic [7:0] q, output logic [3:0] r,
                       output logic dbz, output int lat, output int busy_n);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    step();
    Start    = 1'b0;
    Dividend = 8'($urandom);
    Divisor  = 4'($urandom);
    lat      = 0;
    busy_n   = 0;
    while (1) begin
      if (Busy) busy_n++;
      if (Done) break;
      if (lat >= 40) begin
        chk("done_timeout", lat, -1);
        break;
      end
      step();
      lat++;
    end
    q   = Quotient;
    r   = Remainder;
    dbz = DivByZero;
    step();
    chk("done_one_cycle", int'(Done), 0);
  endtask

  // Reference model: plain integer division; zero divisor saturates.
  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] q, output logic [3:0] r,
                                output logic dbz, output int lat, output int busy_n);
    if (b == 4'd0) begin
      q = 8'hFF; r = a[3:0]; dbz = 1'b1; lat = 0; busy_n = 0;
    end else begin
      q = 8'(a / b); r = 4'(a % b); dbz = 1'b0; lat = 8; busy_n = 8;
    end
  endfunction

  vec_t vecs[8];

  initial begin
    logic [7:0] q, eq;
    logic [3:0] r, er;
    logic       dbz, edbz;
    int         lat, elat, bn, ebn;

    total = 0;
    bad   = 0;
    Reset_b  = 1'b0;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;

    // Zero divisor finishes on the accepting edge itself, so lat is 0 there.
    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8, 8};
    vecs[1] = '{8'd143, 4'd11, 8'd13,  4'd0, 1'b0, 8, 8};
    vecs[2] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8, 8};
    vecs[3] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 8, 8};
    vecs[4] = '{8'd0,   4'd1,  8'd0,   4'd0, 1'b0, 8, 8};
    vecs[5] = '{8'h64,  4'd0,  8'hFF,  4'd4, 1'b1, 0, 0};
    vecs[6] = '{8'd128, 4'd15, 8'd8,   4'd8, 1'b0, 8, 8};
    vecs[7] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8, 8};

    step();
    step();
    chk("rst_quotient",  int'(Quotient),  0);
    chk("rst_remainder", int'(Remainder), 0);
    chk("rst_busy",      int'(Busy),      0);
    chk("rst_done",      int'(Done),      0);
    chk("rst_dbz",       int'(DivByZero), 0);
    Reset_b = 1'b1;
    step();

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, q, r, dbz, lat, bn);
      chk($sformatf("vec%0d_q", i),    int'(q),   int'(vecs[i].exp_q));
      chk($sformatf("vec%0d_r", i),    int'(r),   int'(vecs[i].exp_r));
      chk($sformatf("vec%0d_dbz", i),  int'(dbz), int'(vecs[i].exp_dbz));
      chk($sformatf("vec%0d_lat", i),  lat,       vecs[i].exp_lat);
      chk($sformatf("vec%0d_busy", i), bn,        vecs[i].exp_busy);
    end

    // Outputs hold after completion (last vector was 255/1).
    step();
    step();
    chk("hold_q", int'(Quotient), 255);
    chk("hold_done", int'(Done), 0);

    // Start during RUN and DONE is dropped; first IDLE cycle is accepted.
    Dividend = 8'd200; Divisor = 4'd7; Start = 1'b1;
    step();                                   // edge k: accept
    Start = 1'b0;
    step(); step();                           // k+1, k+2
    Dividend = 8'd50; Divisor = 4'd5; Start = 1'b1;
    step();                                   // k+3: in RUN, ignored
    Start = 1'b0;
    step();                                   // k+4
    chk("midrun_q_unchanged", int'(Quotient), 255);
    step(); step(); step(); step();           // k+5..k+8
    chk("ign_done", int'(Done), 1);
    chk("ign_q", int'(Quotient), 28);
    chk("ign_r", int'(Remainder), 4);
    Dividend = 8'd50; Divisor = 4'd5; Start = 1'b1;
    step();                                   // k+9: in DONE, ignored
    chk("ign_done_busy", int'(Busy), 0);
    chk("ign_done_pulse", int'(Done), 0);
    step();                                   // k+10: first IDLE edge, accepted
    Start = 1'b0;
    chk("b2b_busy", int'(Busy), 1);
    lat = 0;
    while (!Done && lat < 40) begin
      step();
      lat++;
    end
    chk("b2b_lat", lat, 8);
    chk("b2b_q", int'(Quotient), 10);
    chk("b2b_r", int'(Remainder), 0);
    step();

    // Reset in the middle of a run.
    Dividend = 8'd200; Divisor = 4'd7; Start = 1'b1;
    step();                                   // k
    Start = 1'b0;
    step(); step(); step();                   // k+1..k+3
    Reset_b = 1'b0;
    step();                                   // k+4
    chk("mid_rst_q",    int'(Quotient),  0);
    chk("mid_rst_r",    int'(Remainder), 0);
    chk("mid_rst_busy", int'(Busy),      0);
    chk("mid_rst_done", int'(Done),      0);
    chk("mid_rst_dbz",  int'(DivByZero), 0);
    Reset_b = 1'b1;
    step();
    chk("mid_rst_idle", int'(Busy), 0);
    do_op(8'd9, 4'd3, q, r, dbz, lat, bn);
    chk("after_rst_q",   int'(q), 3);
    chk("after_rst_r",   int'(r), 0);
    chk("after_rst_lat", lat,     8);

    // Random operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra;
      logic [3:0] rb;
      ra = 8'($urandom);
      rb = 4'($urandom_range(0, 15));
      model(ra, rb, eq, er, edbz, elat, ebn);
      do_op(ra, rb, q, r, dbz, lat, bn);
      chk($sformatf("rnd%0d_q_%0d/%0d", n, ra, rb), int'(q),   int'(eq));
      chk($sformatf("rnd%0d_r_%0d/%0d", n, ra, rb), int'(r),   int'(er));
      chk($sformatf("rnd%0d_dbz", n),               int'(dbz), int'(edbz));
      chk($sformatf("rnd%0d_lat", n),               lat,       elat);
      chk($sformatf("rnd%0d_busy", n),              bn,        ebn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
